// File: rtl/bit_decompose_64bit.sv
// Splits a 64-bit operand into one-hot masks, one set bit per beat over a valid/ready stream.
// Define BITDECOMP_MSB_FIRST_EN to emit the highest set bit first (descending index order).
module bit_decompose_64bit #(
  parameter int WIDTH = 64,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mask,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] residue;
  logic             zero_flag;
  logic [WIDTH-1:0] sel_mask;
  logic             accept;
  logic             fire;

  // Two's-complement isolate: v & -v keeps only the lowest set bit.
  function automatic logic [WIDTH-1:0] low_bit(input logic [WIDTH-1:0] v);
    return v & (~v + WIDTH'(1));
  endfunction

  function automatic logic [WIDTH-1:0] high_bit(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        m    = '0;
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // Encodes a one-hot (or all-zero) mask to its bit position; zero maps to 0.
  function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (m[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

`ifdef BITDECOMP_MSB_FIRST_EN
  assign sel_mask = high_bit(residue);
`else
  assign sel_mask = low_bit(residue);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Outputs depend only on registered state, never on in_* or out_ready.
  always_comb begin
    state_d   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_mask  = '0;
    out_index = '0;
    out_last  = 1'b0;
    out_zero  = 1'b0;
    accept    = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        out_mask  = sel_mask;
        out_index = encode(sel_mask);
        out_last  = zero_flag | single_bit(residue);
        out_zero  = zero_flag;
        fire      = out_ready;
        if (out_ready && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      residue   <= '0;
      zero_flag <= 1'b0;
    end else if (accept) begin
      residue   <= in_data;
      zero_flag <= (in_data == '0);
    end else if (fire) begin
      residue   <= residue & ~sel_mask;
    end
  end

endmodule

// File: tb/tb_bit_decompose_64bit.sv
// Directed bench for bit_decompose_64bit; mirrors BITDECOMP_MSB_FIRST_EN for expected beat order.
module tb_bit_decompose_64bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_mask;
  logic [5:0]  out_index;
  logic        out_last;
  logic        out_zero;

  int checks   = 0;
  int failures = 0;

  bit_decompose_64bit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mask (out_mask),
    .out_index(out_index),
    .out_last (out_last),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_mask"},  out_mask,       64'd0);
    chk({tag, "_out_index"}, 64'(out_index), 64'd0);
    chk({tag, "_out_last"},  64'(out_last),  64'd0);
    chk({tag, "_out_zero"},  64'(out_zero),  64'd0);
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] op, input int exp_idx, input bit last);
    logic [63:0] m;
    m = (op == 64'd0) ? 64'd0 : (64'd1 << exp_idx);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_inrdy"}, 64'(in_ready),  64'd0);
    chk({tag, "_mask"},  out_mask,       m);
    chk({tag, "_index"}, 64'(out_index), 64'(exp_idx));
    chk({tag, "_last"},  64'(out_last),  64'(last));
    chk({tag, "_zero"},  64'(out_zero),  64'(op == 64'd0));
  endtask

  // Full transaction: expected order built by scanning operand bits directly.
  task automatic run_txn(input string tag, input logic [63:0] op, input int stall0, input bit rand_ready);
    int          idx[$];
    int          nexp;
    int          beats;
    logic [63:0] orr;
    for (int i = 0; i < 64; i++) begin
      if (op[i]) begin
`ifdef BITDECOMP_MSB_FIRST_EN
        idx.push_front(i);
`else
        idx.push_back(i);
`endif
      end
    end
    if (op == 64'd0) idx.push_back(0);
    nexp = idx.size();
    chk({tag, "_accept_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = op;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    in_data  = ~op;
    orr   = 64'd0;
    beats = 0;
    for (int b = 0; b < nexp; b++) begin
      int stalls;
      stalls = (b == 0) ? stall0 : (rand_ready ? int'($urandom_range(0, 2)) : 0);
      for (int s = 0; s < stalls; s++) begin
        out_ready = 1'b0;
        chk_beat({tag, "_stall"}, op, idx[b], b == nexp - 1);
        step();
      end
      chk_beat({tag, "_beat"}, op, idx[b], b == nexp - 1);
      orr   = orr | out_mask;
      beats = beats + (out_valid ? 1 : 0);
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    chk({tag, "_done_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_done_rdy"},   64'(in_ready),  64'd1);
    chk({tag, "_or"},         orr,            op);
    chk({tag, "_beats"},      64'(beats),     64'($countones(op) == 0 ? 1 : $countones(op)));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 64'd0;
    out_ready = 1'b0;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();
    chk_reset_vals("idle");

    run_txn("zero",  64'h0000_0000_0000_0000, 0, 1'b0);
    run_txn("three", 64'h8000_0000_0000_0011, 0, 1'b0);
    run_txn("ones",  64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    run_txn("stall", 64'h0000_0000_0000_0104, 3, 1'b0);

    // Reset in the middle of a transaction discards the remaining beats.
    in_valid  = 1'b1;
    in_data   = 64'h0000_00F0_0000_0000;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
`ifdef BITDECOMP_MSB_FIRST_EN
    chk("mid_index", 64'(out_index), 64'd37);
`else
    chk("mid_index", 64'(out_index), 64'd38);
`endif
    chk("mid_valid", 64'(out_valid), 64'd1);
    chk("mid_last",  64'(out_last),  64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    chk_reset_vals("midrst");
    run_txn("one", 64'h0000_0000_0000_0001, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      logic [63:0] op;
      op = {$urandom, $urandom};
      if (t == 1) op = op & 64'h0000_0100_0020_0000;
      if (t == 2) op = 64'd0;
      run_txn("rand", op, int'($urandom_range(0, 2)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
